// File: rtl/dice_bank_controller.sv
// -----------------------------------------------------------------------------
// dice_bank_controller
//
// Captures a bank of NUM_DICE free-running 3-bit die counters when the player
// presses the roll button. Dice the player holds keep their stored value, but
// only once they have been rolled at least once this turn. Up to MAX_ROLLS rolls
// are accepted per turn. A new_turn pulse clears the bank.
//
// Optional feature, enabled by defining DICE_ROLL_ANIM_EN:
//   An accepted roll starts an animation of ANIM_CYCLES clocks. During the
//   animation the non-held dice follow the running values and busy is high.
//   The value seen on the last animation cycle is the final one. rolled and
//   roll_count update when the animation ends.
//   When the macro is undefined there is no animation state and no counter,
//   and busy is tied low.
//
// Ports
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   roll_btn       in   debounced roll request level (rising edge = request)
//   new_turn       in   one-cycle turn clear (has priority over a request)
//   hold_mask      in   [NUM_DICE]   bit i = 1 keeps die i on the next roll
//   running_value  in   [3*NUM_DICE] free-running die i value at [3i+2:3i]
//   stored_values  out  [3*NUM_DICE] captured die i value at [3i+2:3i]
//   rolled         out  [NUM_DICE]   die i has been captured this turn
//   roll_count     out  accepted rolls this turn
//   turn_done      out  roll_count has reached MAX_ROLLS
//   busy           out  roll animation in progress
// -----------------------------------------------------------------------------
module dice_bank_controller #(
  parameter int NUM_DICE    = 3,
  parameter int MAX_ROLLS   = 3,
  parameter int ANIM_CYCLES = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           roll_btn,
  input  logic                           new_turn,
  input  logic [NUM_DICE-1:0]            hold_mask,
  input  logic [3*NUM_DICE-1:0]          running_value,
  output logic [3*NUM_DICE-1:0]          stored_values,
  output logic [NUM_DICE-1:0]            rolled,
  output logic [$clog2(MAX_ROLLS+1)-1:0] roll_count,
  output logic                           turn_done,
  output logic                           busy
);

  localparam int CW = $clog2(MAX_ROLLS + 1);

  // Reject out-of-range configurations at elaboration time.
  if (NUM_DICE < 1 || NUM_DICE > 8) begin : g_bad_num_dice
    $error("dice_bank_controller: NUM_DICE must be 1..8");
  end
  if (MAX_ROLLS < 1 || MAX_ROLLS > 15) begin : g_bad_max_rolls
    $error("dice_bank_controller: MAX_ROLLS must be 1..15");
  end
  if (ANIM_CYCLES < 2 || ANIM_CYCLES > 255) begin : g_bad_anim_cycles
    $error("dice_bank_controller: ANIM_CYCLES must be 2..255");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // no roll yet this turn
    READY = 2'd1,  // 1..MAX_ROLLS-1 rolls taken
    DONE  = 2'd2   // MAX_ROLLS rolls taken, further presses ignored
`ifdef DICE_ROLL_ANIM_EN
    ,
    ANIM  = 2'd3   // animation running
`endif
  } state_t;

  state_t                state;
  logic                  roll_btn_q;
  logic                  roll_req;
  logic [CW-1:0]         count_inc;
  logic [NUM_DICE-1:0]   keep;
  logic [3*NUM_DICE-1:0] clamped;
  logic [3*NUM_DICE-1:0] capture_next;

`ifdef DICE_ROLL_ANIM_EN
  logic [7:0]            anim_cnt;
  logic [NUM_DICE-1:0]   held_q;
  logic                  busy_q;
`endif

  // Map the 3-bit counter onto die faces: 0 reads as 1, 7 reads as 6.
  function automatic logic [2:0] clamp_die(input logic [2:0] v);
    case (v)
      3'd0:    clamp_die = 3'd1;
      3'd7:    clamp_die = 3'd6;
      default: clamp_die = v;
    endcase
  endfunction

  assign roll_req  = roll_btn & ~roll_btn_q;
  assign count_inc = roll_count + CW'(1);
  assign turn_done = (state == DONE);

`ifdef DICE_ROLL_ANIM_EN
  // The hold pattern is frozen at acceptance so the animation is stable.
  assign keep = held_q;
  assign busy = busy_q;
`else
  // A hold only counts on a die that already has a value this turn.
  assign keep = hold_mask & rolled;
  assign busy = 1'b0;
`endif

  always_comb begin
    // NOTE: defaults first so every path assigns these and no latch is inferred.
    clamped      = '0;
    capture_next = stored_values;
    for (int i = 0; i < NUM_DICE; i++) begin
      clamped[3*i +: 3] = clamp_die(running_value[3*i +: 3]);
      if (!keep[i]) capture_next[3*i +: 3] = clamped[3*i +: 3];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: all state, including the stored dice values, is reset so that a
      // reset in the middle of a roll leaves no partial capture behind.
      state         <= IDLE;
      roll_btn_q    <= 1'b0;
      stored_values <= '0;
      rolled        <= '0;
      roll_count    <= '0;
`ifdef DICE_ROLL_ANIM_EN
      anim_cnt      <= '0;
      held_q        <= '0;
      busy_q        <= 1'b0;
`endif
    end else begin
      roll_btn_q <= roll_btn;
      if (new_turn) begin
        // Clearing the turn wins over any request in the same cycle.
        state         <= IDLE;
        stored_values <= '0;
        rolled        <= '0;
        roll_count    <= '0;
`ifdef DICE_ROLL_ANIM_EN
        anim_cnt      <= '0;
        held_q        <= '0;
        busy_q        <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE, READY: begin
            if (roll_req) begin
`ifdef DICE_ROLL_ANIM_EN
              held_q   <= hold_mask & rolled;
              anim_cnt <= 8'(ANIM_CYCLES - 1);
              busy_q   <= 1'b1;
              state    <= ANIM;
`else
              stored_values <= capture_next;
              rolled        <= '1;
              roll_count    <= count_inc;
              state         <= (count_inc == CW'(MAX_ROLLS)) ? DONE : READY;
`endif
            end
          end
`ifdef DICE_ROLL_ANIM_EN
          ANIM: begin
            // Non-held dice track the running value on every animation cycle;
            // the capture on the final cycle is the one that sticks.
            stored_values <= capture_next;
            if (anim_cnt == 8'd0) begin
              rolled     <= '1;
              roll_count <= count_inc;
              busy_q     <= 1'b0;
              state      <= (count_inc == CW'(MAX_ROLLS)) ? DONE : READY;
            end else begin
              anim_cnt <= anim_cnt - 8'd1;
            end
          end
`endif
          DONE:    ;  // wait for new_turn
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/dice_bank_controller.md
DICE_BANK_CONTROLLER -- requirements
Module: dice_bank_controller

Interface
REQ-001 The block SHALL have parameter NUM_DICE, default 3: number of independent dice channels (1..8).
REQ-002 The block SHALL have parameter MAX_ROLLS, default 3: maximum accepted rolls per turn (1..15).
REQ-003 The block SHALL have parameter ANIM_CYCLES, default 8: animation length in clocks (2..255), used only with DICE_ROLL_ANIM_EN.
REQ-004 The block SHALL have port clk, input, 1: clock; all state changes on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 The block SHALL have port roll_btn, input, 1: synchronous, debounced roll request level.
REQ-007 The block SHALL have port new_turn, input, 1: synchronous one-cycle turn clear.
REQ-008 The block SHALL have port hold_mask, input, NUM_DICE: bit i=1 keeps die i on the next roll.
REQ-009 The block SHALL have port running_value, input, 3*NUM_DICE: free-running die i value at bits [3i+2:3i].
REQ-010 The block SHALL have port stored_values, output, 3*NUM_DICE: captured die i value at bits [3i+2:3i].
REQ-011 The block SHALL have port rolled, output, NUM_DICE: bit i=1 once die i has been captured this turn.
REQ-012 The block SHALL have port roll_count, output, clog2(MAX_ROLLS+1): accepted rolls this turn.
REQ-013 The block SHALL have port turn_done, output, 1: high when roll_count equals MAX_ROLLS.
REQ-014 The block SHALL have port busy, output, 1: high while a roll animation is in progress.

Function
REQ-015 The block SHALL detect a roll request as roll_btn high in the current cycle and low in the previous cycle, using a registered copy of roll_btn; a held-high button yields exactly one request.
REQ-016 The block SHALL implement states IDLE (no roll this turn), READY (1..MAX_ROLLS-1 rolls), ANIM (animation, macro only) and DONE (roll_count==MAX_ROLLS).
REQ-017 A request SHALL be accepted only in IDLE or READY; requests in ANIM or DONE SHALL be ignored, not queued.
REQ-018 On acceptance, die i SHALL be captured if hold_mask[i]==0 or rolled[i]==0; hold on a never-rolled die SHALL be ignored.
REQ-019 A captured running value of 0 SHALL be stored as 1 and 7 as 6; values 1..6 SHALL be stored unchanged.
REQ-020 Without animation, capture, rolled update and roll_count increment SHALL occur on the clock edge at which the request is detected, visible the following cycle.
REQ-021 An accepted roll with every die held SHALL still increment roll_count and change no stored value.
REQ-022 After the increment, the state SHALL go to DONE if roll_count==MAX_ROLLS, else READY; turn_done SHALL be asserted combinationally from DONE.
REQ-023 new_turn SHALL, on the next edge from any state (including ANIM), clear stored_values, rolled and roll_count to 0, deassert busy and enter IDLE.
REQ-024 new_turn and a roll request in the same cycle SHALL resolve to new_turn only; the request SHALL be discarded.

Reset
REQ-025 While rst_n is low, stored_values, rolled and roll_count SHALL be 0, busy and turn_done 0, the state IDLE, and the registered roll_btn copy 0.
REQ-026 Reset deassertion mid-animation SHALL leave no partial capture or pending count.

Configuration
REQ-027 With macro DICE_ROLL_ANIM_EN defined, an accepted roll SHALL latch hold_mask, enter ANIM, and assert busy for exactly ANIM_CYCLES cycles.
REQ-028 With DICE_ROLL_ANIM_EN defined, non-held dice SHALL follow the clamped running_value every ANIM cycle; the value on the last ANIM cycle SHALL be final, and roll_count and rolled SHALL update at ANIM exit.
REQ-029 Without DICE_ROLL_ANIM_EN, the ANIM state and counter SHALL be absent, busy SHALL be constant 0, and ANIM_CYCLES SHALL be ignored.

Verification
REQ-030 Reset, then roll_btn pulse with running_value={3'd5,3'd2,3'd6} -> stored_values={5,2,6}, rolled=3'b111, roll_count=1, state READY.
REQ-031 hold_mask=3'b010, roll with running_value={3'd1,3'd4,3'd3} -> stored_values={1,2,3}, roll_count=2; third roll -> turn_done=1, and a fourth press leaves all outputs unchanged.
REQ-032 roll_btn held high 20 cycles -> roll_count rises by exactly 1; running_value die0=3'd0 and die1=3'd7 -> stored 1 and 6.
REQ-033 new_turn and a roll_btn rising edge in the same cycle from READY -> next cycle all outputs 0, state IDLE, roll_count=0.
REQ-034 With DICE_ROLL_ANIM_EN and ANIM_CYCLES=8: busy high for exactly 8 cycles; presses during busy are ignored; rst_n low at cycle 4 -> all outputs 0, no count.
